switch_dwell_scheduler: RTL
===========================

# switch_dwell_scheduler

Round-robin scheduler that shares one dwell down-counter (load/en/limit/Q interface) among `N_CH` photonic-switch channels. Each channel requests a switching event with its own dwell length. The scheduler grants one channel at a time, loads and enables the shared counter, and holds that channel's switch-select grant until the count reaches zero. An optional guard interval follows each event. It sits between the per-channel decoders and the shared counter, and its `grant` bus drives the switch drivers.

## Interface
- `N_CH`, default 4: number of requesting channels, 2..16.
- `WIDTH`, default 16: dwell/counter width; must match the counter's `WIDTH`.
- `GUARD_CYC`, default 2: guard-interval length in cycles, ≥1. Used only with `DWELL_SCHED_GUARD_EN`.

Ports:
- `clk`  in  1  sole clock; all logic on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req`  in  N_CH  per-channel request; level, held until `done` or abort.
- `dwell`  in  N_CH*WIDTH  packed dwell values; channel i at `[i*WIDTH +: WIDTH]`.
- `grant`  out  N_CH  one-hot switch select; all-zero when idle.
- `busy`  out  1  high in any state other than IDLE.
- `done`  out  1  one-cycle pulse when a dwell completes.
- `abort`  out  1  one-cycle pulse when a dwell is cut short.
- `evt_ch`  out  $clog2(N_CH)  channel index qualifying `done`/`abort`.
- `cnt_load`  out  1  counter load strobe.
- `cnt_en`  out  1  counter enable.
- `cnt_limit`  out  WIDTH  value loaded into the counter.
- `cnt_q`  in  WIDTH  counter's current value.

## Operation
- **Reset:** state IDLE, round-robin pointer 0. `grant`, `busy`, `done`, `abort`, `evt_ch`, `cnt_load`, `cnt_en` and `cnt_limit` are all 0.
- **IDLE:** if any `req` is high, pick the first requester at or after the pointer, wrapping modulo N_CH. Latch its index as `cur` and its `dwell` slice into `cnt_limit`, then go to LOAD. With no request, stay in IDLE.
- **LOAD** (exactly 1 cycle):
  - `grant[cur]`=1, `cnt_load`=1, `cnt_en`=1, so the counter takes `cnt_limit` at the closing edge.
  - Pointer becomes `cur+1` mod N_CH.
  - Next state is COUNT.
- **COUNT:**
  - `grant[cur]`=1, `cnt_load`=0, `cnt_en`=1.
  - When `cnt_q`==0, pulse `done` with `evt_ch`=`cur`, then go to GUARD, or to IDLE when the guard is compiled out.
  - If `req[cur]` drops, pulse `abort` instead, drop `cnt_en`, and take the same next state. This applies even in the cycle where `cnt_q`==0: abort has priority over done.
- **GUARD:** `grant`=0 and `cnt_en`=0. Stay exactly GUARD_CYC cycles using an internal counter, then go to IDLE.
- **Held inputs:** `dwell` is sampled only in IDLE, so later changes do not affect the running event. Requests from other channels are held off until the next IDLE.
- **Reset mid-operation:** reset in any state returns to reset values on the next edge. `grant` drops immediately at that edge, and no `done` or `abort` is generated.
- **`cnt_limit`:** holds its last value outside LOAD.

## Timing
- Request to grant: a `req` rising while in IDLE gives `grant` and `cnt_load` high the next cycle.
- Grant width for dwell D: D+2 cycles (1 LOAD + D+1 COUNT cycles, with `cnt_q` going D..0).
  - D=0 gives 2 cycles.
  - D=2^WIDTH−1 gives 2^WIDTH+1 cycles, with no wrap.
- `done` is coincident with the last `grant` cycle.
- Back-to-back events:
  - With guard: `grant` is all-zero for GUARD_CYC+1 cycles between events (GUARD plus IDLE).
  - Without guard: the gap is 1 cycle (IDLE).
- Fairness: with all channels continuously requesting, grants rotate 0,1,…,N_CH−1,0. No channel waits more than N_CH−1 events.

## Configuration
- `DWELL_SCHED_GUARD_EN` defined: GUARD state and its guard counter are present, and COUNT exits to GUARD.
- Undefined: no GUARD state, COUNT exits directly to IDLE, and `GUARD_CYC` is ignored.

## Test plan
- Reset, then `req`=0 for 10 cycles → `grant`=0, `busy`=0, `cnt_load`=0 throughout.
- `req`=4'b0010, dwell1=5 → `grant`=4'b0010 for 7 cycles, `cnt_load` high only in the first, `done` pulses on the 7th with `evt_ch`=1. Then (guard on, GUARD_CYC=2) `busy` stays high 2 more cycles.
- `req`=4'b1111 held, all dwells=0 → grant order 0,1,2,3,0. Each grant lasts 2 cycles; gaps are 3 cycles with guard, 1 without.
- `req[2]` dropped 3 cycles into a dwell of 10 → `abort` pulse with `evt_ch`=2, no `done`, `grant` cleared next cycle, `cnt_en` low.
- `dwell0` changed from 8 to 1 on the cycle after grant → `grant` still lasts 10 cycles.
- `rst` asserted mid-COUNT → the next edge gives `grant`=0, state IDLE, no pulse on `done` or `abort`. Priority restarts at channel 0.

Source files
------------

// File: rtl/switch_dwell_scheduler.sv
// Round-robin scheduler sharing one dwell down-counter among N_CH switch channels.
// Optional post-event guard interval is compiled in with `define DWELL_SCHED_GUARD_EN.
module switch_dwell_scheduler #(
    parameter int unsigned N_CH      = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned GUARD_CYC = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req,
    input  logic [N_CH*WIDTH-1:0]     dwell,
    output logic [N_CH-1:0]           grant,
    output logic                      busy,
    output logic                      done,
    output logic                      abort,
    output logic [$clog2(N_CH)-1:0]   evt_ch,
    output logic                      cnt_load,
    output logic                      cnt_en,
    output logic [WIDTH-1:0]          cnt_limit,
    input  logic [WIDTH-1:0]          cnt_q
);

    localparam int unsigned CW = $clog2(N_CH);

`ifdef DWELL_SCHED_GUARD_EN
    localparam int unsigned GW = $clog2(GUARD_CYC + 1);
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT, S_GUARD} state_t;
    logic [GW-1:0] gcnt;
`else
    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_COUNT} state_t;
`endif

    state_t          state;
    logic [CW-1:0]   ptr;
    logic [CW-1:0]   cur;
    logic [CW-1:0]   pick;
    logic            pick_vld;
    logic            in_count;

    // First requester at or after the round-robin pointer, wrapping.
    always_comb begin
        logic [CW-1:0] idx;
        idx      = '0;
        pick     = '0;
        pick_vld = 1'b0;
        for (int i = 0; i < N_CH; i++) begin
            idx = CW'((int'(ptr) + i) % N_CH);
            if (!pick_vld && req[idx]) begin
                pick     = idx;
                pick_vld = 1'b1;
            end
        end
    end

    // done/abort must coincide with the cycle that observes cnt_q==0 or the
    // dropped request, so they are decoded from the registered state.
    assign in_count = (state == S_COUNT) && !rst;
    assign abort    = in_count && !req[cur];
    assign done     = in_count && req[cur] && (cnt_q == '0);
    assign evt_ch   = cur;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            ptr       <= '0;
            cur       <= '0;
            grant     <= '0;
            busy      <= 1'b0;
            cnt_load  <= 1'b0;
            cnt_en    <= 1'b0;
            cnt_limit <= '0;
`ifdef DWELL_SCHED_GUARD_EN
            gcnt      <= '0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_vld) begin
                        cur       <= pick;
                        cnt_limit <= dwell[pick*WIDTH +: WIDTH];
                        grant     <= N_CH'(1) << pick;
                        busy      <= 1'b1;
                        cnt_load  <= 1'b1;
                        cnt_en    <= 1'b1;
                        state     <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    cnt_load <= 1'b0;
                    ptr      <= (cur == CW'(N_CH - 1)) ? '0 : cur + 1'b1;
                    state    <= S_COUNT;
                end
                S_COUNT: begin
                    // Abort and normal completion leave COUNT the same way.
                    if (!req[cur] || (cnt_q == '0)) begin
                        grant  <= '0;
                        cnt_en <= 1'b0;
`ifdef DWELL_SCHED_GUARD_EN
                        gcnt   <= '0;
                        state  <= S_GUARD;
`else
                        busy   <= 1'b0;
                        state  <= S_IDLE;
`endif
                    end
                end
`ifdef DWELL_SCHED_GUARD_EN
                S_GUARD: begin
                    if (gcnt == GW'(GUARD_CYC - 1)) begin
                        busy  <= 1'b0;
                        state <= S_IDLE;
                    end else begin
                        gcnt <= gcnt + 1'b1;
                    end
                end
`endif
                default: begin
                    grant    <= '0;
                    busy     <= 1'b0;
                    cnt_load <= 1'b0;
                    cnt_en   <= 1'b0;
                    state    <= S_IDLE;
                end
            endcase
        end
    end

    // Catch illegal parameterisations in simulation.
    always_ff @(posedge clk) begin : param_check
        assert (N_CH >= 2 && N_CH <= 16 && GUARD_CYC >= 1)
            else $error("switch_dwell_scheduler: parameter out of range");
    end

endmodule
